scic_memory: RTL and testbench

//  Memory-side responder for the SCIC CPU bus: 16-bit word address, 32-bit read/write data, single write strobe.

---
 rtl/scic_memory_pkg.sv | 15 +
 rtl/scic_memory_if.sv | 12 +
 rtl/scic_word_assembler.sv | 43 ++++
 rtl/scic_memory.sv | 106 ++++++++++
 tb/tb_scic_memory.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/scic_memory_pkg.sv
// Shared types and constants for the SCIC memory responder: MMIO map, ID word, loader FSM states.
package scic_pkg;

  localparam logic [15:0] MMIO_GPIO = 16'd0;
  localparam logic [15:0] MMIO_CNT  = 16'd1;
  localparam logic [15:0] MMIO_ID   = 16'd2;

  localparam logic [31:0] SCIC_ID = 32'h5C1C_0001;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/scic_memory_if.sv
// SCIC CPU bus: word address, write data and write strobe from the CPU, combinational read data back.
// The bus has no valid/ready: a write takes effect at any posedge with we=1, and rdata follows address
// in the same cycle. The loader port is separate; a byte moves on a posedge with load_valid && load_ready.
interface scic_memory_if;
  logic [15:0] address;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output address, output wdata, output we, input rdata);
  modport slave  (input address, input wdata, input we, output rdata);
endinterface

// File: rtl/scic_word_assembler.sv
// Big-endian byte-to-word assembler for the program loader; presents either a full word or a
// zero-padded partial word (including any byte arriving in the same cycle) for the RAM write.
module scic_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic        flush,
  output logic        word_valid,
  output logic        flush_valid,
  output logic [31:0] word
);

  logic [23:0] held;
  logic [1:0]  count;
  logic [2:0]  fill;
  logic [31:0] cur;

  // held keeps the most recent bytes in its low lanes; only the low 'count' bytes are meaningful.
  always_comb begin
    cur         = accept ? {held, byte_in} : {8'h00, held};
    fill        = {1'b0, count} + {2'b00, accept};
    word_valid  = (fill == 3'd4);
    flush_valid = flush && (fill != 3'd0) && (fill != 3'd4);
    case (fill)
      3'd1:    word = {cur[7:0], 24'h0};
      3'd2:    word = {cur[15:0], 16'h0};
      3'd3:    word = {cur[23:0], 8'h0};
      default: word = cur;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      held  <= '0;
      count <= '0;
    end else if (accept) begin
      held  <= {held[15:0], byte_in};
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/scic_memory.sv
// SCIC memory-side responder: word RAM, MMIO window (GPIO, cycle counter, ID) and a byte-stream
// loader that fills RAM while holding the CPU in reset, then releases it.
module scic_memory
  import scic_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
  input  logic         clock,
  input  logic         reset,
  scic_memory_if.slave bus,
  output logic         cpu_reset,
  input  logic         load_valid,
  input  logic [7:0]   load_byte,
  input  logic         load_done,
  output logic         load_ready,
  output logic [31:0]  gpio_out,
  output state_t       state
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0]           ram [DEPTH];
  logic [31:0]           cycle_cnt;
  logic [DEPTH_LOG2-1:0] load_ptr;

  logic        in_load;
  logic        accept;
  logic        flush;
  logic        word_valid;
  logic        flush_valid;
  logic [31:0] asm_word;
  logic        load_we;
  logic        in_ram;
  logic        run_we;

  assign in_load = (state == LOAD);
  assign accept  = in_load && load_valid;
  assign flush   = in_load && load_done;
  assign load_we = word_valid || flush_valid;
  assign in_ram  = (bus.address < 16'(DEPTH));
  assign run_we  = (state == RUN) && bus.we;

  scic_word_assembler u_asm (
    .clock       (clock),
    .reset       (reset),
    .accept      (accept),
    .byte_in     (load_byte),
    .flush       (flush),
    .word_valid  (word_valid),
    .flush_valid (flush_valid),
    .word        (asm_word)
  );

  // RAM has no reset so a program survives a CPU restart.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (load_we)
        ram[load_ptr] <= asm_word;
      else if (run_we && in_ram)
        ram[bus.address[DEPTH_LOG2-1:0]] <= bus.wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOAD;
      cpu_reset  <= 1'b1;
      load_ready <= 1'b1;
      gpio_out   <= '0;
      cycle_cnt  <= '0;
      load_ptr   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (word_valid)
            load_ptr <= load_ptr + 1'b1;
          if (load_done) begin
            state      <= RUN;
            cpu_reset  <= 1'b0;
            load_ready <= 1'b0;
          end
        end
        RUN: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (bus.we && bus.address == MMIO_BASE + MMIO_GPIO)
            gpio_out <= bus.wdata;
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (in_ram)
      bus.rdata = ram[bus.address[DEPTH_LOG2-1:0]];
    else if (bus.address == MMIO_BASE + MMIO_GPIO)
      bus.rdata = gpio_out;
    else if (bus.address == MMIO_BASE + MMIO_CNT)
      bus.rdata = cycle_cnt;
    else if (bus.address == MMIO_BASE + MMIO_ID)
      bus.rdata = SCIC_ID;
  end

endmodule

// File: tb/tb_scic_memory.sv
// Directed bench for scic_memory: loader framing, padding, MMIO decode, counter and reload behaviour.
module tb_scic_memory;
  import scic_pkg::*;

  logic        clock;
  logic        reset;
  logic        cpu_reset;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_done;
  logic        load_ready;
  logic [31:0] gpio_out;
  state_t      state;

  int          compared;
  int          mismatched;
  logic        tb_run;
  logic [31:0] run_cnt;

  scic_memory_if bus ();

  scic_memory dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .cpu_reset  (cpu_reset),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_done  (load_done),
    .load_ready (load_ready),
    .gpio_out   (gpio_out),
    .state      (state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected cycle counter: it advances on every edge that starts in RUN.
  task automatic tick();
    @(posedge clock);
    if (tb_run) run_cnt = run_cnt + 32'd1;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset  = 1'b1;
    tb_run = 1'b0;
    tick();
    reset   = 1'b0;
    run_cnt = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic send_done(input logic with_byte, input logic [7:0] b);
    load_done  = 1'b1;
    load_valid = with_byte;
    load_byte  = b;
    tick();
    load_done  = 1'b0;
    load_valid = 1'b0;
    tb_run     = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    bus.address = a;
    bus.wdata   = d;
    bus.we      = 1'b1;
    tick();
    bus.we      = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    tb_run     = 1'b0;
    run_cnt    = '0;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_byte  = '0;
    load_done  = 1'b0;
    bus.address = '0;
    bus.wdata   = '0;
    bus.we      = 1'b0;
    tick();
    do_reset();

    check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    check("rst_load_ready", {31'b0, load_ready}, 32'd1);
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_state", {31'b0, state}, {31'b0, LOAD});
    read_check("rst_counter", 16'hFF01, 32'h0);

    // Two full words, then end of image.
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    load_done = 1'b1;
    #1;
    check("done_cycle_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    load_done = 1'b0;
    send_done(1'b0, 8'h00);
    check("run_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    check("run_load_ready", {31'b0, load_ready}, 32'd0);
    read_check("ram0_word", 16'h0000, 32'h11223344);
    read_check("ram1_word", 16'h0001, 32'h55667788);

    // CPU-side RAM and MMIO access in RUN.
    bus_write(16'h0005, 32'hCAFEF00D);
    read_check("ram5_write", 16'h0005, 32'hCAFEF00D);
    read_check("unmapped_100", 16'h0100, 32'h0);
    read_check("id_read", 16'hFF02, 32'h5C1C_0001);
    read_check("unmapped_ff03", 16'hFF03, 32'h0);
    bus_write(16'hFF00, 32'h0000_00FF);
    check("gpio_write", gpio_out, 32'h0000_00FF);
    read_check("gpio_read", 16'hFF00, 32'h0000_00FF);
    bus_write(16'hFF01, 32'h1234_5678);
    read_check("counter_after_write", 16'hFF01, run_cnt);
    tick(); tick(); tick();
    read_check("counter_plus3", 16'hFF01, run_cnt);
    bus_write(16'hFF02, 32'hFFFF_FFFF);
    read_check("id_write_ignored", 16'hFF02, 32'h5C1C_0001);

    // Three bytes plus a fourth in the load_done cycle.
    do_reset();
    check("rerun_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hBB);
    send_done(1'b1, 8'hCC);
    read_check("done_with_byte", 16'h0000, 32'hAABBBBCC);
    check("done_with_byte_state", {31'b0, state}, {31'b0, RUN});

    // Two-byte partial is zero-padded.
    do_reset();
    send_byte(8'hDE); send_byte(8'hAD);
    send_done(1'b0, 8'h00);
    read_check("partial_pad", 16'h0000, 32'hDEAD0000);
    read_check("ram1_kept", 16'h0001, 32'h55667788);

    // Reset mid-load after six bytes, with CPU writes attempted during LOAD.
    do_reset();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    bus_write(16'h0005, 32'hDEADBEEF);
    bus_write(16'hFF00, 32'h1111_1111);
    read_check("load_we_ignored", 16'h0005, 32'hCAFEF00D);
    check("load_gpio_ignored", gpio_out, 32'h0);
    do_reset();
    check("midload_load_ready", {31'b0, load_ready}, 32'd1);
    check("midload_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    read_check("midload_ram0", 16'h0000, 32'h01020304);
    read_check("midload_ram1", 16'h0001, 32'h55667788);
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
    read_check("ptr_restart", 16'h0000, 32'h0A0B0C0D);
    read_check("partial_dropped", 16'h0001, 32'h55667788);

    // 257 words: pointer wraps and the last word lands at address 0.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      logic [31:0] w;
      w = 32'hA500_0000 + 32'(i);
      send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    end
    send_done(1'b0, 8'h00);
    read_check("wrap_ram0", 16'h0000, 32'hA500_0100);
    read_check("wrap_ram1", 16'h0001, 32'hA500_0001);
    read_check("wrap_ram255", 16'h00FF, 32'hA500_00FF);
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_byte  = 8'(8'h30 + i);
      load_done  = 1'(i % 2);
      tick();
    end
    load_valid = 1'b0;
    load_done  = 1'b0;
    read_check("run_ignores_load0", 16'h0000, 32'hA500_0100);
    read_check("run_ignores_load1", 16'h0001, 32'hA500_0001);
    check("run_state_held", {31'b0, state}, {31'b0, RUN});
    check("run_load_ready_low", {31'b0, load_ready}, 32'd0);
    read_check("run_counter", 16'hFF01, run_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
